cook_timer: RTL and testbench

//  Countdown timer that generates timer_done for the magnetron controller and consumes that controller's Enabler output.

---
 rtl/cook_timer_pkg.sv | 62 ++++++
 rtl/cook_timer_if.sv | 29 ++
 rtl/cook_timer_prescaler.sv | 28 ++
 rtl/cook_timer.sv | 99 +++++++++
 tb/tb_cook_timer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/cook_timer_pkg.sv
// rtl/cook_timer_pkg.sv - shared types, constants and BCD time helpers for the cook timer
// Purpose : state encoding, BCD digit type, maximum time, MM:SS decrement helper.
//           With COOK_ADD30_EN defined it also provides the saturating +30 s helper.
// Ports   : none (package)
package cook_timer_pkg;

    typedef enum logic [1:0] {IDLE, SET, RUN, DONE} cook_state_t;

    typedef logic [3:0] bcd_t;

    localparam logic [15:0] MAX_TIME_BCD = 16'h9959;

    // One-second decrement of {M1,M0,S1,S0}. Borrows reload seconds to 59,
    // so entered seconds of 60-99 simply count down through their own value.
    function automatic logic [15:0] bcd_mmss_dec(input logic [15:0] t);
        bcd_t m1, m0, s1, s0;
        {m1, m0, s1, s0} = t;
        if (s0 != 4'd0) begin
            s0 = s0 - 4'd1;
        end else if (s1 != 4'd0) begin
            s1 = s1 - 4'd1;
            s0 = 4'd9;
        end else if (m0 != 4'd0) begin
            m0 = m0 - 4'd1;
            s1 = 4'd5;
            s0 = 4'd9;
        end else begin
            m1 = m1 - 4'd1;
            m0 = 4'd9;
            s1 = 4'd5;
            s0 = 4'd9;
        end
        return {m1, m0, s1, s0};
    endfunction

`ifdef COOK_ADD30_EN
    function automatic logic [7:0] bin_to_bcd2(input logic [7:0] v);
        logic [7:0] tens;
        logic [7:0] ones;
        tens = v / 8'd10;
        ones = v - tens * 8'd10;
        return {tens[3:0], ones[3:0]};
    endfunction

    // +30 s with one minute carry; anything past 99 minutes saturates.
    function automatic logic [15:0] bcd_mmss_add30(input logic [15:0] t);
        logic [7:0] sec;
        logic [7:0] min;
        sec = {4'd0, t[7:4]} * 8'd10 + {4'd0, t[3:0]} + 8'd30;
        min = {4'd0, t[15:12]} * 8'd10 + {4'd0, t[11:8]};
        if (sec >= 8'd60) begin
            sec = sec - 8'd60;
            min = min + 8'd1;
        end
        if (min > 8'd99) begin
            return MAX_TIME_BCD;
        end
        return {bin_to_bcd2(min), bin_to_bcd2(sec)};
    endfunction
`endif

endpackage

// File: rtl/cook_timer_if.sv
// rtl/cook_timer_if.sv - keypad/enable/status bundle between controller and cook timer
// Purpose : groups keypad entry, clear, enable and timer status signals.
//           add30 exists only when COOK_ADD30_EN is defined.
// Modports: master drives digit_valid/digit/clear/enable(/add30) and reads status;
//           slave (the timer) is the mirror image.
interface cook_timer_if;
    logic        digit_valid;
    logic [3:0]  digit;
    logic        clear;
    logic        enable;
`ifdef COOK_ADD30_EN
    logic        add30;
`endif
    logic [15:0] time_bcd;
    logic        running;
    logic        timer_done;

`ifdef COOK_ADD30_EN
    modport master (output digit_valid, digit, clear, enable, add30,
                    input  time_bcd, running, timer_done);
    modport slave  (input  digit_valid, digit, clear, enable, add30,
                    output time_bcd, running, timer_done);
`else
    modport master (output digit_valid, digit, clear, enable,
                    input  time_bcd, running, timer_done);
    modport slave  (input  digit_valid, digit, clear, enable,
                    output time_bcd, running, timer_done);
`endif
endinterface

// File: rtl/cook_timer_prescaler.sv
// rtl/cook_timer_prescaler.sv - one-second tick prescaler for the cook timer
// Purpose : counts clk cycles while en=1; tick is high on the cycle the count wraps.
// Ports   : clk, rst_n (sync, active-low), en (count), clr (zero count, beats en),
//           tick (one-cycle strobe on wrap)
module tick_prescaler #(
    parameter int TICKS_PER_SEC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [W-1:0] LAST = W'(TICKS_PER_SEC - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/cook_timer.sv
// rtl/cook_timer.sv - BCD MM:SS cook countdown timer
// Purpose : keypad-loaded countdown gated by the magnetron enable; flags expiry.
//           COOK_ADD30_EN adds the +30 s strobe (bus.add30).
// Ports   : clk, rst_n (sync, active-low), bus (cook_timer_if.slave):
//           digit_valid/digit/clear/enable(/add30) in, time_bcd/running/timer_done out
module cook_timer
    import cook_timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1000
) (
    input  logic         clk,
    input  logic         rst_n,
    cook_timer_if.slave  bus
);
    cook_state_t state_q, state_n;
    logic [15:0] time_q, time_n;
    logic [15:0] dec_time;
    logic        running_q, done_q;
    logic        digit_ok;
    logic        pre_en, pre_clr, tick;

    // Counting only happens in RUN with enable held; pausing leaves the
    // prescaler untouched so a resume finishes the interrupted second.
    assign pre_en = (state_q == RUN) && bus.enable;

    tick_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pre_en),
        .clr   (pre_clr),
        .tick  (tick)
    );

    assign bus.time_bcd   = time_q;
    assign bus.running    = running_q;
    assign bus.timer_done = done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            time_q    <= 16'h0000;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            time_q    <= time_n;
            running_q <= (state_n == RUN);
            done_q    <= (state_n == DONE);
        end
    end

    always_comb begin
        state_n  = state_q;
        time_n   = time_q;
        pre_clr  = 1'b0;
        digit_ok = bus.digit_valid && (bus.digit <= 4'd9) && !bus.enable;
        dec_time = bcd_mmss_dec(time_q);

        if (bus.clear) begin
            state_n = IDLE;
            time_n  = 16'h0000;
            pre_clr = 1'b1;
        end
`ifdef COOK_ADD30_EN
        // Applied on top of a same-cycle decrement, so an expiring 00:01 lands on 00:30.
        else if (bus.add30) begin
            time_n  = bcd_mmss_add30(tick ? dec_time : time_q);
            state_n = (state_q == RUN && bus.enable) ? RUN : SET;
            pre_clr = (state_q == IDLE) || (state_q == DONE);
        end
`endif
        else if (digit_ok) begin
            time_n  = (state_q == DONE) ? {12'h000, bus.digit} : {time_q[11:0], bus.digit};
            state_n = (time_n == 16'h0000) ? IDLE : SET;
            pre_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE, SET: begin
                    if (bus.enable) begin
                        state_n = (time_q == 16'h0000) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (!bus.enable) begin
                        state_n = SET;
                    end else if (tick) begin
                        time_n = dec_time;
                        if (dec_time == 16'h0000) begin
                            state_n = DONE;
                        end
                    end
                end
                default: begin
                    state_n = DONE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cook_timer.sv
// tb/tb_cook_timer.sv - directed self-checking bench for cook_timer (TICKS_PER_SEC=4)
module tb_cook_timer;
    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    cook_timer_if bus();

    cook_timer #(.TICKS_PER_SEC(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] d);
        bus.digit       = d;
        bus.digit_valid = 1'b1;
        step();
        bus.digit_valid = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
        bus.clear       = 1'b0;
        bus.enable      = 1'b0;
`ifdef COOK_ADD30_EN
        bus.add30       = 1'b0;
`endif
        step(2);
        if (bus.time_bcd !== 16'h0000) begin $display("FAIL reset_time: got %h exp 0000", bus.time_bcd); miscompares++; end vectors++;
        if (bus.timer_done !== 1'b0) begin $display("FAIL reset_done: got %b exp 0", bus.timer_done); miscompares++; end vectors++;
        if (bus.running !== 1'b0) begin $display("FAIL reset_running: got %b exp 0", bus.running); miscompares++; end vectors++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_countdown();
        press(4'd1); press(4'd0); press(4'd5);
        if (bus.time_bcd !== 16'h0105) begin $display("FAIL load_0105: got %h exp 0105", bus.time_bcd); miscompares++; end vectors++;
        if (bus.running !== 1'b0) begin $display("FAIL set_running: got %b exp 0", bus.running); miscompares++; end vectors++;
        bus.enable = 1'b1;
        step();
        if (bus.running !== 1'b1) begin $display("FAIL run_running: got %b exp 1", bus.running); miscompares++; end vectors++;
        step(3);
        if (bus.time_bcd !== 16'h0105) begin $display("FAIL pre_tick: got %h exp 0105", bus.time_bcd); miscompares++; end vectors++;
        step();
        if (bus.time_bcd !== 16'h0104) begin $display("FAIL first_sec: got %h exp 0104", bus.time_bcd); miscompares++; end vectors++;
        step(64 * 4 - 1);
        if (bus.time_bcd !== 16'h0001 || bus.timer_done !== 1'b0) begin $display("FAIL last_sec: got %h/%b exp 0001/0", bus.time_bcd, bus.timer_done); miscompares++; end vectors++;
        step();
        if (bus.time_bcd !== 16'h0000 || bus.timer_done !== 1'b1 || bus.running !== 1'b0) begin $display("FAIL expiry: got %h/%b/%b exp 0000/1/0", bus.time_bcd, bus.timer_done, bus.running); miscompares++; end vectors++;
        press(4'd3);
        if (bus.time_bcd !== 16'h0000 || bus.timer_done !== 1'b1) begin $display("FAIL done_hold: got %h/%b exp 0000/1", bus.time_bcd, bus.timer_done); miscompares++; end vectors++;
        bus.enable = 1'b0;
        step(3);
        if (bus.timer_done !== 1'b1) begin $display("FAIL done_no_enable: got %b exp 1", bus.timer_done); miscompares++; end vectors++;
        do_clear();
        if (bus.time_bcd !== 16'h0000 || bus.timer_done !== 1'b0) begin $display("FAIL clear_done: got %h/%b exp 0000/0", bus.time_bcd, bus.timer_done); miscompares++; end vectors++;
    endtask

    task automatic test_pause();
        press(4'd1); press(4'd0); press(4'd0);
        bus.enable = 1'b1;
        step();
        step(3);
        if (bus.time_bcd !== 16'h0100) begin $display("FAIL pause_pre: got %h exp 0100", bus.time_bcd); miscompares++; end vectors++;
        step();
        if (bus.time_bcd !== 16'h0059) begin $display("FAIL min_borrow: got %h exp 0059", bus.time_bcd); miscompares++; end vectors++;
        step(2);
        bus.enable = 1'b0;
        step(11);
        if (bus.time_bcd !== 16'h0059 || bus.running !== 1'b0) begin $display("FAIL paused: got %h/%b exp 0059/0", bus.time_bcd, bus.running); miscompares++; end vectors++;
        bus.enable = 1'b1;
        step(2);
        if (bus.time_bcd !== 16'h0059 || bus.running !== 1'b1) begin $display("FAIL resume_partial: got %h/%b exp 0059/1", bus.time_bcd, bus.running); miscompares++; end vectors++;
        step();
        if (bus.time_bcd !== 16'h0058) begin $display("FAIL resume_tick: got %h exp 0058", bus.time_bcd); miscompares++; end vectors++;
        bus.enable = 1'b0;
        do_clear();
    endtask

    task automatic test_zero_enable();
        bus.enable = 1'b1;
        step();
        if (bus.timer_done !== 1'b1 || bus.running !== 1'b0) begin $display("FAIL zero_enable: got %b/%b exp 1/0", bus.timer_done, bus.running); miscompares++; end vectors++;
        press(4'd3);
        if (bus.time_bcd !== 16'h0000) begin $display("FAIL digit_while_enabled: got %h exp 0000", bus.time_bcd); miscompares++; end vectors++;
        bus.enable = 1'b0;
        press(4'd7);
        if (bus.time_bcd !== 16'h0007 || bus.timer_done !== 1'b0) begin $display("FAIL done_reload: got %h/%b exp 0007/0", bus.time_bcd, bus.timer_done); miscompares++; end vectors++;
        press(4'd12);
        if (bus.time_bcd !== 16'h0007) begin $display("FAIL non_bcd_digit: got %h exp 0007", bus.time_bcd); miscompares++; end vectors++;
        bus.enable = 1'b1;
        step(3);
        bus.clear = 1'b1;
        step();
        if (bus.time_bcd !== 16'h0000 || bus.running !== 1'b0 || bus.timer_done !== 1'b0) begin $display("FAIL clear_mid_run: got %h/%b/%b exp 0000/0/0", bus.time_bcd, bus.running, bus.timer_done); miscompares++; end vectors++;
        bus.enable      = 1'b0;
        bus.digit       = 4'd5;
        bus.digit_valid = 1'b1;
        step();
        bus.clear       = 1'b0;
        bus.digit_valid = 1'b0;
        if (bus.time_bcd !== 16'h0000) begin $display("FAIL clear_beats_digit: got %h exp 0000", bus.time_bcd); miscompares++; end vectors++;
    endtask

    task automatic test_borrows();
        press(4'd1); press(4'd0); press(4'd0); press(4'd0);
        bus.enable = 1'b1;
        step(5);
        if (bus.time_bcd !== 16'h0959) begin $display("FAIL tens_min_borrow: got %h exp 0959", bus.time_bcd); miscompares++; end vectors++;
        bus.enable = 1'b0;
        do_clear();
        press(4'd9); press(4'd0);
        bus.enable = 1'b1;
        step(5);
        if (bus.time_bcd !== 16'h0089) begin $display("FAIL sec90_first: got %h exp 0089", bus.time_bcd); miscompares++; end vectors++;
        step(30 * 4);
        if (bus.time_bcd !== 16'h0059) begin $display("FAIL sec90_60_to_59: got %h exp 0059", bus.time_bcd); miscompares++; end vectors++;
        bus.enable = 1'b0;
        do_clear();
    endtask

`ifdef COOK_ADD30_EN
    task automatic test_add30();
        press(4'd9); press(4'd9); press(4'd4); press(4'd5);
        bus.add30 = 1'b1;
        step();
        bus.add30 = 1'b0;
        if (bus.time_bcd !== 16'h9959) begin $display("FAIL add30_saturate: got %h exp 9959", bus.time_bcd); miscompares++; end vectors++;
        do_clear();
        bus.enable = 1'b1;
        step();
        bus.add30 = 1'b1;
        step();
        bus.add30 = 1'b0;
        if (bus.time_bcd !== 16'h0030 || bus.timer_done !== 1'b0 || bus.running !== 1'b0) begin $display("FAIL add30_from_done: got %h/%b/%b exp 0030/0/0", bus.time_bcd, bus.timer_done, bus.running); miscompares++; end vectors++;
        bus.enable = 1'b0;
        do_clear();
        press(4'd1);
        bus.enable = 1'b1;
        step(4);
        bus.add30 = 1'b1;
        step();
        bus.add30 = 1'b0;
        if (bus.time_bcd !== 16'h0030 || bus.timer_done !== 1'b0 || bus.running !== 1'b1) begin $display("FAIL add30_at_expiry: got %h/%b/%b exp 0030/0/1", bus.time_bcd, bus.timer_done, bus.running); miscompares++; end vectors++;
        bus.clear = 1'b1;
        bus.add30 = 1'b1;
        step();
        bus.clear  = 1'b0;
        bus.add30  = 1'b0;
        bus.enable = 1'b0;
        if (bus.time_bcd !== 16'h0000) begin $display("FAIL clear_beats_add30: got %h exp 0000", bus.time_bcd); miscompares++; end vectors++;
    endtask
`endif

    initial begin
        test_reset();
        test_countdown();
        test_pause();
        test_zero_enable();
        test_borrows();
`ifdef COOK_ADD30_EN
        test_add30();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
